// File: rtl/packet_in_fifo.sv
// First-word-fall-through input FIFO for 64-bit NoC packets at one router input port.
// Define PACKET_IN_FIFO_ERR_FLAGS_EN to add sticky overflow/underflow outputs.
module packet_in_fifo #(
  parameter  int WIDTH  = 64,
  parameter  int DEPTH  = 4,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [WIDTH-1:0]  wr_data,
  output logic              full,
  input  logic              rd_en,
  output logic [WIDTH-1:0]  rd_data,
  output logic              empty,
  output logic [ADDR_W:0]   count
`ifdef PACKET_IN_FIFO_ERR_FLAGS_EN
  ,
  output logic              overflow,
  output logic              underflow
`endif
);

  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(DEPTH);

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic [ADDR_W:0]   w_count_next;
  logic              w_full;
  logic              w_empty;
  logic              w_wr_ok;
  logic              w_rd_ok;

  // Flags decode from the registered count only, so upstream may build
  // wr_en from full combinationally without forming a loop.
  assign w_full  = (r_count == FULL_COUNT);
  assign w_empty = (r_count == '0);
  assign w_wr_ok = wr_en & ~w_full;
  assign w_rd_ok = rd_en & ~w_empty;

  // NOTE: every variable written in always_comb gets a default first, otherwise
  // an uncovered path infers a latch.
  always_comb begin
    w_count_next = r_count;
    unique case ({w_wr_ok, w_rd_ok})
      2'b10:   w_count_next = r_count + 1'b1;
      2'b01:   w_count_next = r_count - 1'b1;
      default: w_count_next = r_count;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_ok) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_next;
    end
  end

  // NOTE: the storage array has no reset; pointers and count alone define which
  // entries are live, and a reset-free array maps onto RAM/register-file cells.
  always_ff @(posedge clk) begin
    if (!reset && w_wr_ok) r_mem[r_wr_ptr] <= wr_data;
  end

`ifdef PACKET_IN_FIFO_ERR_FLAGS_EN
  logic r_overflow;
  logic r_underflow;

  // Sticky records of requests that were refused; cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (wr_en && w_full)  r_overflow  <= 1'b1;
      if (rd_en && w_empty) r_underflow <= 1'b1;
    end
  end

  assign overflow  = r_overflow;
  assign underflow = r_underflow;
`endif

  assign full    = w_full;
  assign empty   = w_empty;
  assign count   = r_count;
  assign rd_data = w_empty ? '0 : r_mem[r_rd_ptr];

endmodule

// File: tb/tb_packet_in_fifo.sv
// Self-checking bench for packet_in_fifo: directed scenarios plus randomized traffic
// against a queue-based reference model of a bounded FIFO.
module tb_packet_in_fifo;

  localparam int WIDTH = 64;
  localparam int DEPTH = 4;
  localparam int AW    = $clog2(DEPTH);

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             wr_en = 1'b0;
  logic [WIDTH-1:0] wr_data = '0;
  logic             rd_en = 1'b0;
  logic             full;
  logic             empty;
  logic [WIDTH-1:0] rd_data;
  logic [AW:0]      count;
`ifdef PACKET_IN_FIFO_ERR_FLAGS_EN
  logic             overflow;
  logic             underflow;
  logic             m_ovf = 1'b0;
  logic             m_udf = 1'b0;
`endif

  int total = 0;
  int bad   = 0;

  logic [WIDTH-1:0] model_q [$];

  always #5 clk = ~clk;

  packet_in_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .full    (full),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .empty   (empty),
    .count   (count)
`ifdef PACKET_IN_FIFO_ERR_FLAGS_EN
    ,
    .overflow  (overflow),
    .underflow (underflow)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Compare all visible outputs to the reference model.
  task automatic check_all(input string tag);
    logic [WIDTH-1:0] head;
    head = (model_q.size() > 0) ? model_q[0] : '0;
    check({tag, ".count"}, 64'(count), 64'(model_q.size()));
    check({tag, ".empty"}, 64'(empty), 64'(model_q.size() == 0));
    check({tag, ".full"},  64'(full),  64'(model_q.size() == DEPTH));
    check({tag, ".head"},  rd_data,    head);
`ifdef PACKET_IN_FIFO_ERR_FLAGS_EN
    check({tag, ".ovf"}, 64'(overflow),  64'(m_ovf));
    check({tag, ".udf"}, 64'(underflow), 64'(m_udf));
`endif
  endtask

  // Apply one cycle of stimulus, advance the model by the FIFO rules, then check.
  task automatic step(input logic rst, input logic wr, input logic [WIDTH-1:0] d,
                      input logic rd, input string tag);
    bit was_full, was_empty;
    reset   = rst;
    wr_en   = wr;
    wr_data = d;
    rd_en   = rd;
    @(posedge clk);
    was_full  = (model_q.size() == DEPTH);
    was_empty = (model_q.size() == 0);
    if (rst) begin
      model_q.delete();
`ifdef PACKET_IN_FIFO_ERR_FLAGS_EN
      m_ovf = 1'b0;
      m_udf = 1'b0;
`endif
    end else begin
      if (rd && !was_empty) void'(model_q.pop_front());
      if (wr && !was_full)  model_q.push_back(d);
`ifdef PACKET_IN_FIFO_ERR_FLAGS_EN
      if (wr && was_full)  m_ovf = 1'b1;
      if (rd && was_empty) m_udf = 1'b1;
`endif
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    // Reset state.
    step(1'b1, 1'b0, '0, 1'b0, "reset");
    check("reset.rd_data_zero", rd_data, 64'h0);

    // Fill with A0..A3; head stays A0.
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 64'hA0 + 64'(i), 1'b0, "fill");
      check("fill.count", 64'(count), 64'(i + 1));
      check("fill.head",  rd_data, 64'hA0);
    end
    check("fill.full", 64'(full), 64'h1);

    // Writes while full are dropped.
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b1, 64'hFF, 1'b0, "wfull");
      check("wfull.count", 64'(count), 64'h4);
    end
    for (int i = 0; i < 4; i++) begin
      check("drain.order", rd_data, 64'hA0 + 64'(i));
      step(1'b0, 1'b0, '0, 1'b1, "drain");
    end
    check("drain.empty", 64'(empty), 64'h1);
`ifdef PACKET_IN_FIFO_ERR_FLAGS_EN
    check("drain.ovf_sticky", 64'(overflow), 64'h1);
`endif

    // Read+write on empty: read ignored, write lands.
    step(1'b0, 1'b1, 64'h55, 1'b1, "rwempty");
    check("rwempty.count", 64'(count), 64'h1);
    check("rwempty.head",  rd_data, 64'h55);
`ifdef PACKET_IN_FIFO_ERR_FLAGS_EN
    check("rwempty.udf", 64'(underflow), 64'h1);
`endif

    // Fill up, then read+write while full: pop happens, write refused.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 64'hC0 + 64'(i), 1'b0, "refill");
    check("refill.full", 64'(full), 64'h1);
    step(1'b0, 1'b1, 64'hBB, 1'b1, "rwfull");
    check("rwfull.count", 64'(count), 64'h3);
    check("rwfull.full",  64'(full), 64'h0);
    check("rwfull.head",  rd_data, 64'hC0);
    step(1'b0, 1'b1, 64'hBB, 1'b0, "rwfull2");
    check("rwfull2.count", 64'(count), 64'h4);

    // Streaming across pointer wrap with one entry buffered.
    step(1'b1, 1'b0, '0, 1'b0, "sreset");
    step(1'b0, 1'b1, 64'h00, 1'b0, "prefill");
    for (int i = 0; i < 10; i++) begin
      check("stream.order", rd_data, 64'(i));
      step(1'b0, (i < 9), 64'(i + 1), 1'b1, "stream");
      if (i < 9) check("stream.count", 64'(count), 64'h1);
    end
    check("stream.empty", 64'(empty), 64'h1);

    // Reset mid-operation with wr_en high.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 64'hD0 + 64'(i), 1'b0, "pre_rst");
    step(1'b1, 1'b1, 64'hEE, 1'b1, "midrst");
    check("midrst.count", 64'(count), 64'h0);
    check("midrst.empty", 64'(empty), 64'h1);
    step(1'b0, 1'b1, 64'h77, 1'b0, "post_rst");
    check("post_rst.head", rd_data, 64'h77);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) == 0), $urandom_range(0, 1) == 1,
           {$urandom, $urandom}, $urandom_range(0, 1) == 1, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
